// File: rtl/ca_controller_fsm.sv
// rtl/ca_controller_fsm.sv - LOAD/UPDATE sequencer for the 1-D cellular-automaton engine
// Define CA_MAX_GEN_EN to add the generation limit and the HALT state.
module ca_controller_fsm #(
  parameter int IDX_W     = 10,
  parameter int FIRST_IDX = 1,
  parameter int LAST_IDX  = 1022,
  parameter int MAX_GEN   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ack,
  input  logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] index_next,
  output logic             update,
  output logic             load
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
`ifdef CA_MAX_GEN_EN
  localparam logic [1:0] ST_HALT   = 2'd2;
`endif

  localparam logic [IDX_W-1:0] FIRST_V = IDX_W'(FIRST_IDX);
  localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(LAST_IDX);

  logic [1:0] state_q, state_d;
  logic       sweep_end;

  // The >= test also catches out-of-range indices, so the increment never wraps.
  assign sweep_end = (index >= LAST_V);

`ifdef CA_MAX_GEN_EN
  localparam int               GEN_W     = $clog2(MAX_GEN + 1);
  localparam logic [GEN_W-1:0] MAX_GEN_V = GEN_W'(MAX_GEN);

  logic [GEN_W-1:0] gen_q, gen_d;

  always_comb begin
    gen_d = gen_q;
    if ((state_q == ST_UPDATE) && sweep_end) begin
      gen_d = gen_q + GEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gen_q <= '0;
    end else begin
      gen_q <= gen_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    index_next = FIRST_V;
    case (state_q)
      ST_LOAD: begin
        if (ack) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (sweep_end) begin
`ifdef CA_MAX_GEN_EN
          state_d = (gen_d == MAX_GEN_V) ? ST_HALT : ST_LOAD;
`else
          state_d = ST_LOAD;
`endif
        end else begin
          index_next = index + IDX_W'(1);
        end
      end
`ifdef CA_MAX_GEN_EN
      ST_HALT: begin
        index_next = index;
      end
`endif
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  assign load   = (state_q == ST_LOAD);
  assign update = (state_q == ST_UPDATE);

endmodule

// File: tb/tb_ca_controller_fsm.sv
// tb/tb_ca_controller_fsm.sv - self-checking bench for ca_controller_fsm
// Covers the CA_MAX_GEN_EN build as well when the macro is defined.
module tb_ca_controller_fsm;

  localparam int IDX_W = 10;
  localparam int FIRST = 1;
  localparam int LAST  = 1022;
  localparam int N     = LAST - FIRST + 1;
  localparam int MAXG  = 4;
`ifdef CA_MAX_GEN_EN
  localparam bit GEN_EN = 1'b1;
`else
  localparam bit GEN_EN = 1'b0;
`endif

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             ack     = 1'b0;
  logic             own_idx = 1'b1;
  logic [IDX_W-1:0] idx_reg = '0;
  logic [IDX_W-1:0] idx_drv = '0;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_next;
  logic             update;
  logic             load;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state: remaining sweep cycles, finished sweeps, halted flag
  int left;
  int gens;
  bit halted;

  always #5 clk = ~clk;

  // The bench plays the external index owner unless a vector drives index directly.
  assign index = own_idx ? idx_reg : idx_drv;
  always @(posedge clk) idx_reg <= index_next;

  ca_controller_fsm #(
    .IDX_W    (IDX_W),
    .FIRST_IDX(FIRST),
    .LAST_IDX (LAST),
    .MAX_GEN  (MAXG)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ack       (ack),
    .index     (index),
    .index_next(index_next),
    .update    (update),
    .load      (load)
  );

  typedef struct {
    bit in_upd;
    int idx;
    int exp_next;
    bit exp_load;
    bit exp_upd;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ack     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int  cnt;
    bit  saw_last;
    int  nxt_at_last;
    bit  rst;
    bit  a;
    bit  e_load;
    bit  e_upd;
    int  e_next;

    tbl[0] = '{0,    1,    1, 1, 0};
    tbl[1] = '{0,  700,    1, 1, 0};
    tbl[2] = '{1,    0,    1, 0, 1};
    tbl[3] = '{1,    1,    2, 0, 1};
    tbl[4] = '{1,  511,  512, 0, 1};
    tbl[5] = '{1, 1021, 1022, 0, 1};
    tbl[6] = '{1, 1022,    1, 1, 0};
    tbl[7] = '{1, 1023,    1, 1, 0};

    @(negedge clk);

    // reset state
    do_reset();
    chk("reset_load", load, 1);
    chk("reset_update", update, 0);
    chk("reset_index_next", index_next, FIRST);

    // ack two cycles after load rises, one-cycle pulse
    step();
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    #1;
    chk("ack_update", update, 1);
    chk("ack_load", load, 0);
    chk("ack_index", index, FIRST);
    chk("ack_index_next", index_next, FIRST + 1);

    // full sweep with ack held high throughout (spurious ack)
    ack         = 1'b1;
    cnt         = 0;
    saw_last    = 1'b0;
    nxt_at_last = -1;
    while (update && cnt < 2000) begin
      if (index == LAST) begin
        saw_last    = 1'b1;
        nxt_at_last = int'(index_next);
      end
      cnt++;
      step();
    end
    chk("sweep_length", cnt, N);
    chk("sweep_saw_last", saw_last, 1);
    chk("sweep_last_next", nxt_at_last, FIRST);
    chk("sweep_end_load", load, 1);
    chk("sweep_end_update", update, 0);
    ack = 1'b0;

    // table: index_next decode and the following state for chosen indices
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (tbl[i].in_upd) begin
        ack = 1'b1;
        step();
        ack = 1'b0;
      end
      own_idx = 1'b0;
      idx_drv = IDX_W'(tbl[i].idx);
      #1;
      chk($sformatf("tbl%0d_index_next", i), index_next, tbl[i].exp_next);
      step();
      chk($sformatf("tbl%0d_load", i), load, tbl[i].exp_load);
      chk($sformatf("tbl%0d_update", i), update, tbl[i].exp_upd);
      own_idx = 1'b1;
    end

    // randomized ack/reset against the sweep-counting model
    do_reset();
    left   = 0;
    gens   = 0;
    halted = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      rst     = ($urandom_range(0, 999) != 0);
      a       = ($urandom_range(0, 3) == 0);
      reset_n = rst;
      ack     = a;
      #1;
      e_load = !halted && (left == 0);
      e_upd  = (left > 0);
      if (halted)        e_next = int'(index);
      else if (left > 1) e_next = FIRST + (N - left) + 1;
      else               e_next = FIRST;
      chk("rnd_load", load, e_load);
      chk("rnd_update", update, e_upd);
      chk("rnd_index_next", index_next, e_next);
      chk("rnd_exclusive", load & update, 0);
      if (!rst) begin
        left   = 0;
        gens   = 0;
        halted = 1'b0;
      end else if (halted) begin
        left = 0;
      end else if (left == 0) begin
        if (a) left = N;
      end else begin
        left--;
        if (left == 0 && GEN_EN) begin
          gens++;
          if (gens == MAXG) halted = 1'b1;
        end
      end
      step();
    end
    reset_n = 1'b1;
    ack     = 1'b0;

`ifdef CA_MAX_GEN_EN
    // generation limit: four back-to-back sweeps then permanent halt
    do_reset();
    ack = 1'b1;
    for (int c = 0; c < MAXG * (N + 1); c++) step();
    ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("halt_load", load, 0);
      chk("halt_update", update, 0);
      chk("halt_index_next", index_next, index);
      step();
    end
    do_reset();
    chk("halt_reset_load", load, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
